// File: rtl/mux2_1.sv
// Parameterised 2:1 word mux with a combinational result, a one-cycle registered
// copy, a registered select, and a saturating counter of sampled select transitions.

module mux2_1_lane (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module mux2_1 #(
  parameter int N     = 31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N:0]       in1,
  input  logic [N:0]       in2,
  input  logic             sel,
  output logic [N:0]       out_mux,
  output logic [N:0]       out_mux_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic [N:0]       w_mux;
  logic             w_toggle;
  logic             w_sat;
  logic [N:0]       r_out_q;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_cnt;

  // One lane per bit, all driven by the same select so the word never mixes.
  genvar g;
  generate
    for (g = 0; g <= N; g++) begin : g_lane
      mux2_1_lane u_lane (
        .i_a  (in1[g]),
        .i_b  (in2[g]),
        .i_sel(sel),
        .o_y  (w_mux[g])
      );
    end
  endgenerate

  assign out_mux  = w_mux;
  assign w_toggle = sel ^ r_sel_q;
  assign w_sat    = &r_cnt;

  // After reset r_sel_q is 0, so a high sel on the first live edge counts once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q <= '0;
      r_sel_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_out_q <= w_mux;
      r_sel_q <= sel;
      if (w_toggle && !w_sat) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_mux_q  = r_out_q;
  assign sel_q      = r_sel_q;
  assign toggle_cnt = r_cnt;

endmodule

// File: tb/tb_mux2_1.sv
// Directed bench for mux2_1: combinational vector table, N=0/N=7 width sweeps,
// registered path, synchronous reset, mid-run reset and counter saturation.

module tb_mux2_1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1, in2;
  logic        sel;
  logic [31:0] out_mux, out_mux_q;
  logic        sel_q;
  logic [15:0] toggle_cnt;

  logic        sel3;
  logic [31:0] out3, out3_q;
  logic        sel3_q;
  logic [2:0]  cnt3;

  logic [7:0]  a8, b8, y8, y8_q;
  logic        s8, s8_q;
  logic [15:0] c8;

  logic [0:0]  a1, b1, y1, y1_q;
  logic        s1, s1_q;
  logic [15:0] c1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2_1 #(.N(31), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sel(sel),
    .out_mux(out_mux), .out_mux_q(out_mux_q), .sel_q(sel_q), .toggle_cnt(toggle_cnt));

  mux2_1 #(.N(31), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .sel(sel3),
    .out_mux(out3), .out_mux_q(out3_q), .sel_q(sel3_q), .toggle_cnt(cnt3));

  mux2_1 #(.N(7), .CNT_W(16)) u_n7 (
    .clk(clk), .rst(rst), .in1(a8), .in2(b8), .sel(s8),
    .out_mux(y8), .out_mux_q(y8_q), .sel_q(s8_q), .toggle_cnt(c8));

  mux2_1 #(.N(0), .CNT_W(16)) u_n0 (
    .clk(clk), .rst(rst), .in1(a1), .in2(b1), .sel(s1),
    .out_mux(y1), .out_mux_q(y1_q), .sel_q(s1_q), .toggle_cnt(c1));

  typedef struct {
    logic        sel;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int errs;
    logic [2:0] idx;
    rst = 1'b1; sel = 1'b0; sel3 = 1'b0; in1 = '0; in2 = '0;
    a8 = '0; b8 = '0; s8 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'hA5A5_5A5A, 32'h1234_5678, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 32'hA5A5_5A5A, 32'h1234_5678, 32'h1234_5678};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 32'h8000_0001, 32'h7FFF_FFFE, 32'h8000_0001};
    vecs[6] = '{1'b1, 32'h8000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFE};
    vecs[7] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};

    // Combinational table, run while held in reset: out_mux must not care.
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel; in1 = vecs[i].in1; in2 = vecs[i].in2;
      #1;
      chk($sformatf("comb_vec%0d", i), out_mux, vecs[i].exp);
    end

    @(negedge clk);
    chk("rst_out_q", out_mux_q, 32'h0);
    chk("rst_sel_q", {31'b0, sel_q}, 32'h0);
    chk("rst_cnt", {16'b0, toggle_cnt}, 32'h0);
    chk("rst_cnt3", {29'b0, cnt3}, 32'h0);

    // Reset held two cycles with sel=1: comb path live, registers cleared.
    sel = 1'b1; in1 = 32'h0; in2 = 32'hDEAD_BEEF;
    #1 chk("rst_comb", out_mux, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("rst%0d_out", i), out_mux, 32'hDEAD_BEEF);
      chk($sformatf("rst%0d_out_q", i), out_mux_q, 32'h0);
      chk($sformatf("rst%0d_sel_q", i), {31'b0, sel_q}, 32'h0);
      chk($sformatf("rst%0d_cnt", i), {16'b0, toggle_cnt}, 32'h0);
    end
    rst = 1'b0;
    cyc();
    chk("post_rst_out_q", out_mux_q, 32'hDEAD_BEEF);
    chk("post_rst_sel_q", {31'b0, sel_q}, 32'h1);
    chk("post_rst_cnt", {16'b0, toggle_cnt}, 32'h1);

    // Registered path lags the combinational one by exactly one edge.
    sel = 1'b0; in1 = 32'hA5A5_5A5A; in2 = 32'h1234_5678;
    #1 chk("pipe0_comb", out_mux, 32'hA5A5_5A5A);
    chk("pipe0_q_old", out_mux_q, 32'hDEAD_BEEF);
    cyc();
    chk("pipe0_q", out_mux_q, 32'hA5A5_5A5A);
    chk("pipe0_cnt", {16'b0, toggle_cnt}, 32'h2);
    sel = 1'b1;
    #1 chk("pipe1_comb", out_mux, 32'h1234_5678);
    chk("pipe1_q_old", out_mux_q, 32'hA5A5_5A5A);
    cyc();
    chk("pipe1_q", out_mux_q, 32'h1234_5678);
    chk("pipe1_cnt", {16'b0, toggle_cnt}, 32'h3);
    in2 = 32'hCAFE_F00D;
    cyc();
    chk("hold_q", out_mux_q, 32'hCAFE_F00D);
    chk("hold_cnt", {16'b0, toggle_cnt}, 32'h3);
    sel = 1'b0;
    cyc();
    chk("tog4_q", out_mux_q, 32'hA5A5_5A5A);
    sel = 1'b1;
    cyc();
    chk("tog5_cnt", {16'b0, toggle_cnt}, 32'h5);

    // Mid-run reset with sel toggling: nothing moves until the edge.
    rst = 1'b1; sel = 1'b0;
    #1 chk("mid_pre_q", out_mux_q, 32'hCAFE_F00D);
    chk("mid_pre_cnt", {16'b0, toggle_cnt}, 32'h5);
    cyc();
    chk("mid_q", out_mux_q, 32'h0);
    chk("mid_sel_q", {31'b0, sel_q}, 32'h0);
    chk("mid_cnt", {16'b0, toggle_cnt}, 32'h0);
    rst = 1'b0; sel = 1'b1;
    cyc();
    chk("mid_resume1", {16'b0, toggle_cnt}, 32'h1);
    chk("mid_resume_q", out_mux_q, 32'hCAFE_F00D);
    sel = 1'b0;
    cyc();
    chk("mid_resume2", {16'b0, toggle_cnt}, 32'h2);

    // 3-bit counter: toggling every cycle counts 1..7 then sticks.
    for (int i = 0; i < 10; i++) begin
      sel3 = ~sel3;
      cyc();
      chk($sformatf("sat%0d", i), {29'b0, cnt3}, (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end

    // N=0: all eight combinations.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      a1 = idx[0]; b1 = idx[1]; s1 = idx[2];
      #1 chk($sformatf("n0_%0d", i), {31'b0, y1}, {31'b0, s1 ? b1 : a1});
    end

    // N=7: exhaustive sweep, folded into one comparison.
    errs = 0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 256; b++) begin
          a8 = 8'(a); b8 = 8'(b); s8 = s[0];
          #1;
          if (y8 !== (s8 ? b8 : a8)) errs++;
        end
    chk("n7_sweep_errs", 32'(errs), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
